// File: rtl/output_tile_collector.sv
// rtl/output_tile_collector.sv - de-skews systolic column results into double-buffered 4x4 tiles and streams packed rows
module output_tile_collector #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_W-1:0]       c0_in,
  input  logic [DATA_W-1:0]       c1_in,
  input  logic [DATA_W-1:0]       c2_in,
  input  logic [DATA_W-1:0]       c3_in,
  input  logic                    valid_c0,
  input  logic                    valid_c1,
  input  logic                    valid_c2,
  input  logic                    valid_c3,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [1:0]              out_row,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overflow,
  output logic [CNT_W-1:0]        tiles_done
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t                   r_state;
  logic [DATA_W-1:0]        r_tile [2][LANES][LANES];
  logic [1:0]               r_lane_row [LANES];
  logic [LANES-1:0]         r_lane_buf;
  logic [LANES-1:0]         r_done [2];
  logic                     r_rbuf;
  logic [LANES*DATA_W-1:0]  r_out_data;
  logic [1:0]               r_out_row;
  logic                     r_out_valid;
  logic                     r_overflow;
  logic [CNT_W-1:0]         r_tiles_done;

  logic [DATA_W-1:0]        w_lane_data [LANES];
  logic [LANES-1:0]         w_lane_valid;
  logic [LANES-1:0]         w_accept;
  logic [1:0]               w_full;
  logic                     w_drain_done;
  logic                     w_sel_buf;
  logic [1:0]               w_sel_row;
  logic [LANES*DATA_W-1:0]  w_sel_word;

  // Gather the per-column ports into indexable lane arrays
  always_comb begin
    w_lane_data[0] = c0_in;
    w_lane_data[1] = c1_in;
    w_lane_data[2] = c2_in;
    w_lane_data[3] = c3_in;
  end

  assign w_lane_valid = {valid_c3, valid_c2, valid_c1, valid_c0};
  assign w_full[0]    = &r_done[0];
  assign w_full[1]    = &r_done[1];

  // Row-3 handshake frees the buffer being drained in this very cycle
  assign w_drain_done = (r_state == S_EMIT) && r_out_valid && out_ready && (r_out_row == 2'd3);

  // A lane may write while its target column is free, or is being freed right now
  always_comb begin
    w_accept = '0;
    for (int c = 0; c < LANES; c++) begin
      w_accept[c] = w_lane_valid[c] &&
                    (!r_done[r_lane_buf[c]][c] ||
                     (w_drain_done && (r_lane_buf[c] == r_rbuf)));
    end
  end

  // Pick the row to present next: row 0 from idle, next row, or row 0 of the other buffer
  always_comb begin
    w_sel_buf  = r_rbuf;
    w_sel_row  = 2'd0;
    if (r_state == S_EMIT) begin
      if (r_out_row == 2'd3) begin
        w_sel_buf = ~r_rbuf;
      end else begin
        w_sel_row = r_out_row + 2'd1;
      end
    end
    w_sel_word = '0;
    for (int c = 0; c < LANES; c++) begin
      w_sel_word[(LANES-1-c)*DATA_W +: DATA_W] = r_tile[w_sel_buf][w_sel_row][c];
    end
  end

  // Tile storage: contents need no reset, lane state decides what is valid
  always_ff @(posedge clk) begin
    if (!start) begin
      for (int c = 0; c < LANES; c++) begin
        if (w_accept[c]) begin
          r_tile[r_lane_buf[c]][r_lane_row[c]][c] <= w_lane_data[c];
        end
      end
    end
  end

  // Per-lane capture state, done flags and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < LANES; c++) r_lane_row[c] <= 2'd0;
      r_lane_buf <= '0;
      r_done[0]  <= '0;
      r_done[1]  <= '0;
      r_overflow <= 1'b0;
    end else if (start) begin
      for (int c = 0; c < LANES; c++) r_lane_row[c] <= 2'd0;
      r_lane_buf <= '0;
      r_done[0]  <= '0;
      r_done[1]  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_drain_done) begin
        r_done[r_rbuf] <= '0;
      end
      for (int c = 0; c < LANES; c++) begin
        if (w_accept[c]) begin
          r_lane_row[c] <= r_lane_row[c] + 2'd1;
          if (r_lane_row[c] == 2'd3) begin
            r_done[r_lane_buf[c]][c] <= 1'b1;
            r_lane_buf[c]            <= ~r_lane_buf[c];
          end
        end else if (w_lane_valid[c]) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  // Drain FSM: streams four rows per full buffer, chaining buffers without bubbles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_rbuf       <= 1'b0;
      r_out_data   <= '0;
      r_out_row    <= 2'd0;
      r_out_valid  <= 1'b0;
      r_tiles_done <= '0;
    end else if (start) begin
      r_state      <= S_IDLE;
      r_rbuf       <= 1'b0;
      r_out_data   <= '0;
      r_out_row    <= 2'd0;
      r_out_valid  <= 1'b0;
      r_tiles_done <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_full[r_rbuf]) begin
            r_out_data  <= w_sel_word;
            r_out_row   <= 2'd0;
            r_out_valid <= 1'b1;
            r_state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (r_out_row != 2'd3) begin
              r_out_data <= w_sel_word;
              r_out_row  <= r_out_row + 2'd1;
            end else begin
              r_rbuf       <= ~r_rbuf;
              r_tiles_done <= r_tiles_done + CNT_W'(1);
              if (w_full[~r_rbuf]) begin
                r_out_data <= w_sel_word;
                r_out_row  <= 2'd0;
              end else begin
                r_out_data  <= '0;
                r_out_row   <= 2'd0;
                r_out_valid <= 1'b0;
                r_state     <= S_IDLE;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_data   = r_out_data;
  assign out_row    = r_out_row;
  assign out_valid  = r_out_valid;
  assign out_last   = (r_out_row == 2'd3) && r_out_valid;
  assign busy       = (|r_done[0]) || (|r_done[1]) || r_out_valid;
  assign overflow   = r_overflow;
  assign tiles_done = r_tiles_done;

endmodule
